// File: rtl/lane_stream_serializer_pkg.sv
// Shared types and defaults for the lane stream serializer.
// Lane types mirror the producer's packed per-lane constant array.
package lane_stream_pkg;

    localparam int NLANES_DEF = 8;
    localparam int LANEW_DEF  = 6;

    typedef logic [LANEW_DEF-1:0] lane_t;
    typedef lane_t [NLANES_DEF-1:0] lane_vec_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } lss_state_e;

endpackage

// File: rtl/lane_stream_serializer_if.sv
// Wide-in / narrow-out stream bundle: one packed vector in, one lane per beat out.
// slave is the serializer's view, master is the view of whatever drives it.
interface lane_stream_serializer_if import lane_stream_pkg::*; #(
    parameter int NLANES = NLANES_DEF,
    parameter int LANEW  = LANEW_DEF
) ();
    localparam int IDXW = $clog2(NLANES);

    logic                    in_valid;
    logic                    in_ready;
    logic [NLANES*LANEW-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANEW-1:0]        out_data;
    logic [IDXW-1:0]         out_idx;
    logic                    out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/lane_stream_serializer_lane_select.sv
// Combinational pick of one lane from a packed vector; the beat count is
// mapped to a lane number according to the emission order.
module lane_select import lane_stream_pkg::*; #(
    parameter int  NLANES    = NLANES_DEF,
    parameter int  LANEW     = LANEW_DEF,
    parameter int  LSB_FIRST = 0,
    localparam int IDXW      = $clog2(NLANES)
) (
    input  logic [NLANES*LANEW-1:0] i_vec,
    input  logic [IDXW-1:0]         i_cnt,
    output logic [LANEW-1:0]        o_lane,
    output logic [IDXW-1:0]         o_idx
);
    logic [LANEW-1:0] w_lanes [NLANES];

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            assign w_lanes[gi] = i_vec[gi*LANEW +: LANEW];
        end
    endgenerate

    assign o_idx  = (LSB_FIRST != 0) ? i_cnt : IDXW'(NLANES - 1) - i_cnt;
    assign o_lane = w_lanes[o_idx];
endmodule

// File: rtl/lane_stream_serializer.sv
// Serializes one packed NLANES x LANEW vector per handshake into a lane-per-beat
// stream, MSB lane first by default; back-to-back vectors stream without bubbles.
module lane_stream_serializer import lane_stream_pkg::*; #(
    parameter int NLANES    = NLANES_DEF,
    parameter int LANEW     = LANEW_DEF,
    parameter int LSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    lane_stream_serializer_if.slave  s
);
    localparam int IDXW = $clog2(NLANES);

    lss_state_e              r_state;
    logic [IDXW-1:0]         r_cnt;
    logic [NLANES*LANEW-1:0] r_hold;

    logic                    w_out_valid;
    logic                    w_last;
    logic                    w_out_fire;
    logic [LANEW-1:0]        w_lane;
    logic [IDXW-1:0]         w_idx;

    lane_select #(
        .NLANES    (NLANES),
        .LANEW     (LANEW),
        .LSB_FIRST (LSB_FIRST)
    ) u_lane_select (
        .i_vec  (r_hold),
        .i_cnt  (r_cnt),
        .o_lane (w_lane),
        .o_idx  (w_idx)
    );

    assign w_out_valid = (r_state == SHIFT);
    assign w_last      = w_out_valid && (r_cnt == IDXW'(NLANES - 1));
    assign w_out_fire  = w_out_valid && s.out_ready;

    // The out_ready -> in_ready path is what lets a new vector load on the final beat.
    assign s.in_ready  = (r_state == IDLE) || (w_out_fire && w_last);
    assign s.out_valid = w_out_valid;
    assign s.out_data  = w_lane;
    assign s.out_idx   = w_out_valid ? w_idx : '0;
    assign s.out_last  = w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s.in_valid) begin
                        r_hold  <= s.in_data;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Without out_ready nothing moves, so the presented lane stays put.
                    if (s.out_ready) begin
                        if (!w_last) begin
                            r_cnt <= r_cnt + IDXW'(1);
                        end else if (s.in_valid) begin
                            r_hold <= s.in_data;
                            r_cnt  <= '0;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule
